// File: rtl/vga_pkg.sv
// Shared types, default 640x480 timing and bus-slicing helper for the VGA
// object compositor.
package vga_pkg;

  typedef logic [11:0] rgb12_t;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // LSB of object idx's field inside a flattened obj_* bus of field width w.
  function automatic int unsigned obj_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with active flag, raw sync windows and
// the frame-end strobe used to latch object shadows.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned CNT_W    = 11
) (
  input  logic             div_clk,
  input  logic             reset,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             active,
  output logic             hs_win,
  output logic             vs_win,
  output logic             frame_end
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;
  logic             h_last;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    h_last = (hc_q == H_LAST);
    hc_d   = h_last ? '0 : hc_q + CNT_W'(1);
    vc_d   = vc_q;
    if (h_last) begin
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge div_clk) begin
    if (!reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hc        = hc_q;
  assign vc        = vc_q;
  assign active    = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
  assign hs_win    = (hc_q >= HS_START) && (hc_q < HS_END);
  assign vs_win    = (vc_q >= VS_START) && (vc_q < VS_END);
  assign frame_end = h_last && (vc_q == V_LAST);

endmodule

// File: rtl/vga_obj_compositor.sv
// Composites NUM_OBJ frame-latched rectangles over a background colour and
// drives VGA colour and syncs through a two-stage pipeline behind the counters.
module vga_obj_compositor
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter logic        SYNC_ACT = 1'b0,
  parameter int unsigned NUM_OBJ  = 8,
  parameter int unsigned COORD_W  = 10
) (
  input  logic                       div_clk,
  input  logic                       reset,
  input  logic [NUM_OBJ-1:0]         obj_en,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_x,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_y,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_w,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_h,
  input  logic [NUM_OBJ*12-1:0]      obj_rgb,
  input  logic [11:0]                bg_rgb,
  output logic                       hsync,
  output logic                       vsync,
  output logic [3:0]                 red,
  output logic [3:0]                 green,
  output logic [3:0]                 blue,
  output logic                       frame_tick
);

  localparam int unsigned H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HV_W   = ($clog2(H_TOT) > $clog2(V_TOT)) ? $clog2(H_TOT) : $clog2(V_TOT);
  localparam int unsigned CNT_W  = (HV_W > COORD_W + 1) ? HV_W : COORD_W + 1;

  logic [CNT_W-1:0] hc, vc;
  logic             active, hs_win, vs_win, frame_end;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .CNT_W    (CNT_W)
  ) u_timing (
    .div_clk   (div_clk),
    .reset     (reset),
    .hc        (hc),
    .vc        (vc),
    .active    (active),
    .hs_win    (hs_win),
    .vs_win    (vs_win),
    .frame_end (frame_end)
  );

  // Shadow copies of the object attributes, refreshed only at frame end.
  logic   [NUM_OBJ-1:0]         en_q, en_d;
  logic   [NUM_OBJ*COORD_W-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  rgb12_t [NUM_OBJ-1:0]         rgb_sh_q, rgb_sh_d;

  always_comb begin
    en_d     = en_q;
    x_d      = x_q;
    y_d      = y_q;
    w_d      = w_q;
    h_d      = h_q;
    rgb_sh_d = rgb_sh_q;
    if (frame_end) begin
      en_d     = obj_en;
      x_d      = obj_x;
      y_d      = obj_y;
      w_d      = obj_w;
      h_d      = obj_h;
      rgb_sh_d = obj_rgb;
    end
  end

  always_ff @(posedge div_clk) begin
    if (!reset) en_q <= '0;
    else        en_q <= en_d;
  end

  // NOTE: geometry/colour shadows carry no reset; en_q masks them until the first latch.
  always_ff @(posedge div_clk) begin
    x_q      <= x_d;
    y_q      <= y_d;
    w_q      <= w_d;
    h_q      <= h_d;
    rgb_sh_q <= rgb_sh_d;
  end

  // Hit test at COORD_W+1 bits so x+w never wraps back onto low columns.
  logic [NUM_OBJ-1:0] hit;

  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_hit
    logic [COORD_W:0] x_s, x_e, y_s, y_e;
    assign x_s    = {1'b0, x_q[obj_lsb(i, COORD_W) +: COORD_W]};
    assign x_e    = x_s + {1'b0, w_q[obj_lsb(i, COORD_W) +: COORD_W]};
    assign y_s    = {1'b0, y_q[obj_lsb(i, COORD_W) +: COORD_W]};
    assign y_e    = y_s + {1'b0, h_q[obj_lsb(i, COORD_W) +: COORD_W]};
    assign hit[i] = en_q[i]
                 && (CNT_W'(x_s) <= hc) && (hc < CNT_W'(x_e))
                 && (CNT_W'(y_s) <= vc) && (vc < CNT_W'(y_e));
  end

  logic [NUM_OBJ-1:0] hit1_q, hit1_d;
  logic               act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  rgb12_t             pix_q, pix_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;

  always_comb begin
    hit1_d = hit;
    act1_d = active;
    hs1_d  = hs_win;
    vs1_d  = vs_win;
    pix_d  = '0;
    if (act1_q) begin
      pix_d = bg_rgb;
      // Walk from the top index down so the lowest hitting index wins.
      for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
        if (hit1_q[i]) pix_d = rgb_sh_q[i];
      end
    end
    hsync_d = hs1_q ? SYNC_ACT : ~SYNC_ACT;
    vsync_d = vs1_q ? SYNC_ACT : ~SYNC_ACT;
  end

  always_ff @(posedge div_clk) begin
    if (!reset) begin
      hit1_q  <= '0;
      act1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      pix_q   <= '0;
      hsync_q <= ~SYNC_ACT;
      vsync_q <= ~SYNC_ACT;
    end else begin
      hit1_q  <= hit1_d;
      act1_q  <= act1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      pix_q   <= pix_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign red        = pix_q[11:8];
  assign green      = pix_q[7:4];
  assign blue       = pix_q[3:0];
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_end;

endmodule

// File: tb/tb_vga_obj_compositor.sv
// Directed bench for vga_obj_compositor on a shrunken 80x55 raster so whole
// frames can be swept pixel by pixel against an independent raster model.
`timescale 1ns/1ps
module tb_vga_obj_compositor;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int N  = 8;
  localparam int CW = 10;

  logic            div_clk = 1'b0;
  logic            reset   = 1'b0;
  logic [N-1:0]    obj_en  = '0;
  logic [N*CW-1:0] obj_x   = '0;
  logic [N*CW-1:0] obj_y   = '0;
  logic [N*CW-1:0] obj_w   = '0;
  logic [N*CW-1:0] obj_h   = '0;
  logic [N*12-1:0] obj_rgb = '0;
  logic [11:0]     bg_rgb  = '0;
  logic            hsync, vsync, frame_tick;
  logic [3:0]      red, green, blue;

  int errors = 0;
  int checks = 0;

  // Model copy of what the DUT should have latched for the frame being swept.
  int          m_en[N], m_x[N], m_y[N], m_w[N], m_h[N];
  logic [11:0] m_rgb[N];
  logic [11:0] m_bg;

  always #5 div_clk = ~div_clk;

  vga_obj_compositor #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_ACT (1'b0), .NUM_OBJ (N), .COORD_W (CW)
  ) dut (
    .div_clk    (div_clk),
    .reset      (reset),
    .obj_en     (obj_en),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .obj_w      (obj_w),
    .obj_h      (obj_h),
    .obj_rgb    (obj_rgb),
    .bg_rgb     (bg_rgb),
    .hsync      (hsync),
    .vsync      (vsync),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .frame_tick (frame_tick)
  );

  task automatic set_obj(input int i, input bit en, input int x, input int y,
                         input int w, input int h, input logic [11:0] rgb);
    obj_en[i]             = en;
    obj_x[i*CW +: CW]     = CW'(x);
    obj_y[i*CW +: CW]     = CW'(y);
    obj_w[i*CW +: CW]     = CW'(w);
    obj_h[i*CW +: CW]     = CW'(h);
    obj_rgb[i*12 +: 12]   = rgb;
  endtask

  // Capture the stimulus the DUT is about to latch; objs=0 models an empty shadow.
  task automatic snapshot(input bit objs);
    for (int i = 0; i < N; i++) begin
      m_en[i]  = objs ? int'(obj_en[i]) : 0;
      m_x[i]   = int'(obj_x[i*CW +: CW]);
      m_y[i]   = int'(obj_y[i*CW +: CW]);
      m_w[i]   = int'(obj_w[i*CW +: CW]);
      m_h[i]   = int'(obj_h[i*CW +: CW]);
      m_rgb[i] = obj_rgb[i*12 +: 12];
    end
    m_bg = bg_rgb;
  endtask

  // {rgb, hsync, vsync} expected at raster position (h, v).
  function automatic logic [13:0] expect_px(input int h, input int v);
    logic [11:0] px;
    logic        hs, vs;
    px = 12'h000;
    if (h < HA && v < VA) begin
      px = m_bg;
      for (int i = N - 1; i >= 0; i--) begin
        if (m_en[i] != 0 && h >= m_x[i] && h < m_x[i] + m_w[i] &&
            v >= m_y[i] && v < m_y[i] + m_h[i]) px = m_rgb[i];
      end
    end
    hs = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
    vs = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
    return {px, hs, vs};
  endfunction

  // Sweeps count cycles; sample j shows pixel p0+j (negative = blank/idle).
  // Counter value at each sample is p+2. Returns tallies; tests compare them.
  task automatic run_frame(input int p0, input int count, input int chg_line, input int chg_x,
                           output int bad_pix, output int bad_sync, output int n_lit,
                           output int n_ticks, output int tick_at, output int hs_fall1,
                           output int hs_fall2, output int hs_len, output string first_bad);
    logic [13:0] ex;
    int          p;
    bit          hs_prev;
    bad_pix = 0; bad_sync = 0; n_lit = 0; n_ticks = 0; tick_at = -1;
    hs_fall1 = -1; hs_fall2 = -1; hs_len = 0; first_bad = "none"; hs_prev = 1'b1;
    for (int j = 0; j < count; j++) begin
      @(posedge div_clk);
      @(negedge div_clk);
      p = p0 + j;
      if (p < 0) ex = {12'h000, 1'b1, 1'b1};
      else       ex = expect_px(p % HT, p / HT);
      if ({red, green, blue} !== ex[13:2]) begin
        bad_pix++;
        if (bad_pix == 1)
          first_bad = $sformatf("h=%0d v=%0d got=%h exp=%h", p % HT, p / HT, {red, green, blue}, ex[13:2]);
      end
      if ({hsync, vsync} !== ex[1:0]) bad_sync++;
      if ({red, green, blue} !== 12'h000) n_lit++;
      if (frame_tick === 1'b1) begin
        n_ticks++;
        if (tick_at < 0) tick_at = p + 2;
      end
      if (hsync === 1'b0) begin
        if (hs_prev) begin
          if (hs_fall1 < 0)      hs_fall1 = p + 2;
          else if (hs_fall2 < 0) hs_fall2 = p + 2;
        end
        if (hs_fall2 < 0) hs_len++;
      end
      hs_prev = (hsync !== 1'b0);
      if (chg_line >= 0 && p == chg_line * HT) obj_x[0 +: CW] = CW'(chg_x);
    end
  endtask

  task automatic test_reset();
    int bp, bs, nl, nt, ta, f1, f2, hl;
    string fb;
    set_obj(0, 1'b1, 10, 5, 10, 4, 12'hF00);
    bg_rgb = 12'h5A3;
    for (int c = 0; c < 5; c++) begin
      @(negedge div_clk);
      checks++;
      if ({red, green, blue, hsync, vsync, frame_tick} !== {12'h000, 1'b1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold c=%0d: got rgb=%h hs=%b vs=%b tick=%b, required rgb=000 hs=1 vs=1 tick=0",
                 c, {red, green, blue}, hsync, vsync, frame_tick);
      end
    end
    reset = 1'b1;
    snapshot(1'b0);
    run_frame(-1, FRAME - 1, -1, 0, bp, bs, nl, nt, ta, f1, f2, hl, fb);
    checks++;
    if (bp !== 0) begin errors++; $display("FAIL reset_bg_only: bad=%0d required=0 (%s)", bp, fb); end
    checks++;
    if (bs !== 0) begin errors++; $display("FAIL reset_sync: bad=%0d required=0", bs); end
    checks++;
    if (f1 !== HA + HF + 2) begin errors++; $display("FAIL hsync_first: got=%0d required=%0d", f1, HA + HF + 2); end
    checks++;
    if (hl !== HS) begin errors++; $display("FAIL hsync_width: got=%0d required=%0d", hl, HS); end
    checks++;
    if (f2 - f1 !== HT) begin errors++; $display("FAIL line_period: got=%0d required=%0d", f2 - f1, HT); end
    checks++;
    if (ta !== FRAME - 1 || nt !== 1) begin
      errors++;
      $display("FAIL first_tick: got at=%0d n=%0d required at=%0d n=1", ta, nt, FRAME - 1);
    end
    checks++;
    if (nl !== HA * VA) begin errors++; $display("FAIL reset_lit: got=%0d required=%0d", nl, HA * VA); end
  endtask

  task automatic test_single_object();
    int bp, bs, nl, nt, ta, f1, f2, hl;
    string fb;
    set_obj(0, 1'b1, 10, 5, 10, 4, 12'hF00);
    bg_rgb = 12'h000;
    snapshot(1'b1);
    run_frame(-2, FRAME, -1, 0, bp, bs, nl, nt, ta, f1, f2, hl, fb);
    checks++;
    if (bp !== 0) begin errors++; $display("FAIL single_pix: bad=%0d required=0 (%s)", bp, fb); end
    checks++;
    if (nl !== 40) begin errors++; $display("FAIL single_lit: got=%0d required=40", nl); end
    checks++;
    if (ta !== FRAME - 1 || nt !== 1) begin
      errors++;
      $display("FAIL frame_period: got at=%0d n=%0d required at=%0d n=1", ta, nt, FRAME - 1);
    end
  endtask

  task automatic test_priority();
    int bp, bs, nl, nt, ta, f1, f2, hl;
    string fb;
    set_obj(0, 1'b1, 20, 20, 8, 8, 12'h00F);
    set_obj(3, 1'b1, 16, 16, 12, 12, 12'hFF0);
    snapshot(1'b1);
    run_frame(-2, FRAME, -1, 0, bp, bs, nl, nt, ta, f1, f2, hl, fb);
    checks++;
    if (bp !== 0) begin errors++; $display("FAIL prio_low_wins: bad=%0d required=0 (%s)", bp, fb); end
    checks++;
    if (nl !== 144) begin errors++; $display("FAIL prio_lit: got=%0d required=144", nl); end
    obj_en[0] = 1'b0;
    snapshot(1'b1);
    run_frame(-2, FRAME, -1, 0, bp, bs, nl, nt, ta, f1, f2, hl, fb);
    checks++;
    if (bp !== 0) begin errors++; $display("FAIL prio_obj3_only: bad=%0d required=0 (%s)", bp, fb); end
  endtask

  task automatic test_midframe_change();
    int bp, bs, nl, nt, ta, f1, f2, hl;
    string fb;
    set_obj(3, 1'b0, 0, 0, 0, 0, 12'h000);
    set_obj(0, 1'b1, 10, 0, 4, 48, 12'h0F0);
    snapshot(1'b1);
    run_frame(-2, FRAME, 24, 30, bp, bs, nl, nt, ta, f1, f2, hl, fb);
    checks++;
    if (bp !== 0) begin errors++; $display("FAIL midframe_hold: bad=%0d required=0 (%s)", bp, fb); end
    snapshot(1'b1);
    run_frame(-2, FRAME, -1, 0, bp, bs, nl, nt, ta, f1, f2, hl, fb);
    checks++;
    if (bp !== 0) begin errors++; $display("FAIL midframe_next: bad=%0d required=0 (%s)", bp, fb); end
    checks++;
    if (nl !== 192) begin errors++; $display("FAIL midframe_lit: got=%0d required=192", nl); end
  endtask

  task automatic test_no_wrap();
    int bp, bs, nl, nt, ta, f1, f2, hl;
    string fb;
    set_obj(0, 1'b1, 1020, 0, 10, 48, 12'hFFF);
    set_obj(1, 1'b1, 5, 5, 0, 10, 12'hF0F);
    set_obj(2, 1'b1, 40, 10, 3, 0, 12'h0FF);
    bg_rgb = 12'h0A0;
    snapshot(1'b1);
    run_frame(-2, FRAME, -1, 0, bp, bs, nl, nt, ta, f1, f2, hl, fb);
    checks++;
    if (bp !== 0) begin errors++; $display("FAIL no_wrap_zero_size: bad=%0d required=0 (%s)", bp, fb); end
  endtask

  task automatic test_reset_midframe();
    int bp, bs, nl, nt, ta, f1, f2, hl;
    string fb;
    for (int i = 0; i < N; i++) set_obj(i, 1'b0, 0, 0, 0, 0, 12'h000);
    set_obj(0, 1'b1, 10, 5, 10, 4, 12'hF00);
    bg_rgb = 12'hABC;
    snapshot(1'b1);
    run_frame(-2, 10 * HT + 31, -1, 0, bp, bs, nl, nt, ta, f1, f2, hl, fb);
    checks++;
    if (bp !== 0 || nt !== 0) begin
      errors++;
      $display("FAIL pre_reset_frame: bad=%0d ticks=%0d required 0/0 (%s)", bp, nt, fb);
    end
    reset = 1'b0;
    @(posedge div_clk);
    @(negedge div_clk);
    checks++;
    if ({red, green, blue, hsync, vsync, frame_tick} !== {12'h000, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midframe_reset: got rgb=%h hs=%b vs=%b tick=%b, required rgb=000 hs=1 vs=1 tick=0",
               {red, green, blue}, hsync, vsync, frame_tick);
    end
    @(negedge div_clk);
    reset = 1'b1;
    snapshot(1'b0);
    run_frame(-1, FRAME - 1, -1, 0, bp, bs, nl, nt, ta, f1, f2, hl, fb);
    checks++;
    if (bp !== 0 || bs !== 0) begin
      errors++;
      $display("FAIL restart_frame: bad_pix=%0d bad_sync=%0d required 0/0 (%s)", bp, bs, fb);
    end
    checks++;
    if (ta !== FRAME - 1 || nt !== 1) begin
      errors++;
      $display("FAIL restart_tick: got at=%0d n=%0d required at=%0d n=1", ta, nt, FRAME - 1);
    end
  endtask

  initial begin
    test_reset();
    test_single_object();
    test_priority();
    test_midframe_change();
    test_no_wrap();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
